// File: rtl/sram_obi_arbiter_if.sv
// Bus bundle for the SRAM OBI arbiter: instruction port, data port,
// shared SRAM port and the protocol error flag.
interface sram_obi_arbiter_if;
  // Instruction port (read-only)
  logic        i_req_i;
  logic        i_gnt_o;
  logic [31:0] i_addr_i;
  logic        i_rvalid_o;
  logic [31:0] i_rdata_o;
  // Data port
  logic        d_req_i;
  logic        d_gnt_o;
  logic [31:0] d_addr_i;
  logic        d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_wdata_i;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  // Shared single-port SRAM
  logic        sram_req_o;
  logic        sram_gnt_i;
  logic [31:0] sram_addr_o;
  logic        sram_we_o;
  logic [3:0]  sram_be_o;
  logic [31:0] sram_wdata_o;
  logic        sram_rvalid_i;
  logic [31:0] sram_rdata_i;
  // Unexpected-response flag
  logic        protocol_err_o;

  // Arbiter side
  modport slave (
    input  i_req_i, i_addr_i,
    input  d_req_i, d_addr_i, d_we_i, d_be_i, d_wdata_i,
    input  sram_gnt_i, sram_rvalid_i, sram_rdata_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output sram_req_o, sram_addr_o, sram_we_o, sram_be_o, sram_wdata_o,
    output protocol_err_o
  );

  // Requester / SRAM-model side
  modport master (
    output i_req_i, i_addr_i,
    output d_req_i, d_addr_i, d_we_i, d_be_i, d_wdata_i,
    output sram_gnt_i, sram_rvalid_i, sram_rdata_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  sram_req_o, sram_addr_o, sram_we_o, sram_be_o, sram_wdata_o,
    input  protocol_err_o
  );
endinterface

// File: rtl/sram_obi_arbiter.sv
// Two-port OBI arbiter in front of a single-port SRAM. The data port has
// priority; the instruction port wins once it has lost STARVE_LIMIT data
// handshakes in a row. An ordered ID FIFO routes in-order SRAM responses
// back to the port that issued each transaction.
module sram_obi_arbiter #(
  parameter int unsigned OSTD_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  sram_obi_arbiter_if.slave   bus
);

  localparam int unsigned PW = (OSTD_DEPTH > 1) ? $clog2(OSTD_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OSTD_DEPTH);
  localparam logic [3:0]    LIMIT_C = 4'(STARVE_LIMIT);

  logic [OSTD_DEPTH-1:0] id_q, id_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [3:0]            starve_q, starve_d;
  logic                  perr_q, perr_d;

  logic full, empty, instr_win, req, hs, pop, head_id;

  // Arbitration and request mux; full is taken from the registered count so
  // a response never feeds back into the grant path in the same cycle.
  always_comb begin
    full      = (count_q == DEPTH_C);
    instr_win = bus.i_req_i & (~bus.d_req_i | (starve_q == LIMIT_C));
    req       = (bus.i_req_i | bus.d_req_i) & ~full & ~rst_i;
    hs        = req & bus.sram_gnt_i;
    bus.sram_req_o = req;
    bus.i_gnt_o    = hs & instr_win;
    bus.d_gnt_o    = hs & ~instr_win;
    if (instr_win) begin
      bus.sram_addr_o  = bus.i_addr_i;
      bus.sram_we_o    = 1'b0;
      bus.sram_be_o    = 4'hF;
      bus.sram_wdata_o = 32'h0000_0000;
    end else begin
      bus.sram_addr_o  = bus.d_addr_i;
      bus.sram_we_o    = bus.d_we_i;
      bus.sram_be_o    = bus.d_be_i;
      bus.sram_wdata_o = bus.d_wdata_i;
    end
  end

  // Zero-latency response routing by the ID at the head of the FIFO.
  always_comb begin
    empty   = (count_q == {CW{1'b0}});
    head_id = id_q[rd_ptr_q];
    pop     = bus.sram_rvalid_i & ~empty & ~rst_i;
    bus.i_rvalid_o = pop & ~head_id;
    bus.d_rvalid_o = pop & head_id;
    if (bus.i_rvalid_o) begin
      bus.i_rdata_o = bus.sram_rdata_i;
    end else begin
      bus.i_rdata_o = 32'h0000_0000;
    end
    if (bus.d_rvalid_o) begin
      bus.d_rdata_o = bus.sram_rdata_i;
    end else begin
      bus.d_rdata_o = 32'h0000_0000;
    end
  end

  assign bus.protocol_err_o = perr_q;

  // Next-state: ID FIFO push/pop, starvation counter, error pulse.
  always_comb begin
    id_d     = id_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    perr_d   = bus.sram_rvalid_i & empty;

    if (hs) begin
      id_d[wr_ptr_q] = ~instr_win;
      wr_ptr_d       = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({hs, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (!bus.i_req_i) begin
      starve_d = 4'd0;
    end else if (hs && instr_win) begin
      starve_d = 4'd0;
    end else if (hs && (starve_q != LIMIT_C)) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // State registers with synchronous reset; reset abandons anything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q     <= {OSTD_DEPTH{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      starve_q <= 4'd0;
      perr_q   <= 1'b0;
    end else begin
      id_q     <= id_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      perr_q   <= perr_d;
    end
  end

endmodule

// File: tb/tb_sram_obi_arbiter.sv
// Self-checking bench for sram_obi_arbiter (OSTD_DEPTH=2, STARVE_LIMIT=4).
// Directed scenarios plus a randomized run against a queue-based model.
module tb_sram_obi_arbiter;

  localparam int OSTD  = 2;
  localparam int LIMIT = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  sram_obi_arbiter_if bus();

  sram_obi_arbiter #(.OSTD_DEPTH(OSTD), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ordered list of outstanding source IDs (0=I, 1=D)
  bit idq[$];
  int starve_m = 0;
  bit perr_m   = 1'b0;

  // Expectations for the current cycle
  logic        e_req, e_igt, e_dgt, e_irv, e_drv, e_we, e_perr, e_iwin;
  logic [31:0] e_addr, e_wd, e_ird, e_drd;
  logic [3:0]  e_be;
  // Model updates applied at the next edge
  bit n_rst, n_pop, n_push, n_id, n_perr;
  int n_starve;

  task automatic drive(input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic [31:0] daddr,
                       input logic dwe, input logic [3:0] dbe,
                       input logic [31:0] dwd, input logic sgnt,
                       input logic srv, input logic [31:0] srd);
    bit full, popok;
    bus.i_req_i = ireq;  bus.i_addr_i = iaddr;
    bus.d_req_i = dreq;  bus.d_addr_i = daddr;
    bus.d_we_i  = dwe;   bus.d_be_i   = dbe;   bus.d_wdata_i = dwd;
    bus.sram_gnt_i = sgnt; bus.sram_rvalid_i = srv; bus.sram_rdata_i = srd;
    #4;
    full   = (idq.size() == OSTD);
    e_iwin = ireq && (!dreq || starve_m == LIMIT);
    e_req  = (ireq || dreq) && !full && !rst;
    e_igt  = e_req && sgnt && e_iwin;
    e_dgt  = e_req && sgnt && !e_iwin;
    popok  = srv && (idq.size() > 0) && !rst;
    e_irv  = popok && (idq[0] == 1'b0);
    e_drv  = popok && (idq[0] == 1'b1);
    e_ird  = e_irv ? srd : 32'h0;
    e_drd  = e_drv ? srd : 32'h0;
    e_addr = e_iwin ? iaddr : daddr;
    e_we   = e_iwin ? 1'b0 : dwe;
    e_be   = e_iwin ? 4'hF : dbe;
    e_wd   = e_iwin ? 32'h0 : dwd;
    e_perr = perr_m;
    n_rst  = rst;
    n_pop  = popok;
    n_push = e_igt || e_dgt;
    n_id   = e_dgt;
    n_perr = srv && (idq.size() == 0);
    if (!ireq)       n_starve = 0;
    else if (e_igt)  n_starve = 0;
    else if (e_dgt)  n_starve = (starve_m + 1 > LIMIT) ? LIMIT : starve_m + 1;
    else             n_starve = starve_m;
  endtask

  task automatic tick();
    @(posedge clk);
    if (n_rst) begin
      idq.delete(); starve_m = 0; perr_m = 1'b0;
    end else begin
      if (n_pop)  void'(idq.pop_front());
      if (n_push) idq.push_back(n_id);
      starve_m = n_starve;
      perr_m   = n_perr;
    end
    #1;
  endtask

  task automatic idle(input logic srv, input logic [31:0] srd);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, srv, srd);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, $urandom, 1'b1, $urandom, 1'b1, 4'hF, $urandom, 1'b1, 1'b1, $urandom);
      checks++;
      if ({bus.sram_req_o, bus.i_gnt_o, bus.d_gnt_o, bus.i_rvalid_o, bus.d_rvalid_o} !== 5'b0) begin
        errors++;
        $display("FAIL reset_outputs got %b want 00000",
                 {bus.sram_req_o, bus.i_gnt_o, bus.d_gnt_o, bus.i_rvalid_o, bus.d_rvalid_o});
      end
      tick();
    end
    rst = 1'b0;
    idle(1'b0, 32'h0);
    checks++;
    if (bus.protocol_err_o !== 1'b0) begin
      errors++; $display("FAIL reset_perr got %b want 0", bus.protocol_err_o);
    end
    tick();
  endtask

  task automatic test_instr_read();
    drive(1'b1, 32'h8000_0010, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({bus.i_gnt_o, bus.d_gnt_o, bus.sram_req_o} !== 3'b101) begin
      errors++; $display("FAIL ird_gnt got %b want 101", {bus.i_gnt_o, bus.d_gnt_o, bus.sram_req_o});
    end
    checks++;
    if ({bus.sram_addr_o, bus.sram_we_o, bus.sram_be_o, bus.sram_wdata_o} !== {32'h8000_0010, 1'b0, 4'hF, 32'h0}) begin
      errors++; $display("FAIL ird_fields got %h/%b/%h/%h want 80000010/0/f/0",
                         bus.sram_addr_o, bus.sram_we_o, bus.sram_be_o, bus.sram_wdata_o);
    end
    tick();
    idle(1'b1, 32'h1234_5678);
    checks++;
    if ({bus.i_rvalid_o, bus.d_rvalid_o, bus.i_rdata_o, bus.d_rdata_o} !== {1'b1, 1'b0, 32'h1234_5678, 32'h0}) begin
      errors++; $display("FAIL ird_resp got %b%b %h %h want 10 12345678 0",
                         bus.i_rvalid_o, bus.d_rvalid_o, bus.i_rdata_o, bus.d_rdata_o);
    end
    tick();
  endtask

  task automatic test_write();
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0040, 1'b1, 4'b0011, 32'hAABB_CCDD, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({bus.d_gnt_o, bus.i_gnt_o, bus.sram_we_o, bus.sram_be_o, bus.sram_wdata_o, bus.sram_addr_o}
        !== {1'b1, 1'b0, 1'b1, 4'b0011, 32'hAABB_CCDD, 32'h0000_0040}) begin
      errors++; $display("FAIL wr_fields got %b%b%b %b %h %h", bus.d_gnt_o, bus.i_gnt_o,
                         bus.sram_we_o, bus.sram_be_o, bus.sram_wdata_o, bus.sram_addr_o);
    end
    tick();
    idle(1'b1, 32'h0000_0001);
    checks++;
    if ({bus.d_rvalid_o, bus.i_rvalid_o, bus.i_rdata_o} !== {1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL wr_resp got %b%b %h want 10 0", bus.d_rvalid_o, bus.i_rvalid_o, bus.i_rdata_o);
    end
    tick();
  endtask

  // Both ports request every cycle; instr must win on every fifth grant.
  task automatic starve_run(input string name);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h100 + k, 1'b1, 32'h200 + k, 1'b0, 4'hF, 32'h0, 1'b1, k > 0, 32'h5000 + k);
      checks++;
      if ({bus.i_gnt_o, bus.d_gnt_o} !== {(k % 5) == 4, (k % 5) != 4}) begin
        errors++; $display("FAIL %s_gnt cycle %0d got %b%b want %b%b", name, k, bus.i_gnt_o,
                           bus.d_gnt_o, (k % 5) == 4, (k % 5) != 4);
      end
      if (k > 0) begin
        checks++;
        if ({bus.i_rvalid_o, bus.d_rvalid_o} !== {((k - 1) % 5) == 4, ((k - 1) % 5) != 4}) begin
          errors++; $display("FAIL %s_route cycle %0d got %b%b", name, k, bus.i_rvalid_o, bus.d_rvalid_o);
        end
      end
      tick();
    end
    idle(1'b1, 32'h0);
    tick();
  endtask

  task automatic test_starvation();
    starve_run("starve");
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'hA0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus.i_gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_g1 got %b want 1", bus.i_gnt_o); end
    tick();
    drive(1'b0, 32'h0, 1'b1, 32'hD1, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus.d_gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_g2 got %b want 1", bus.d_gnt_o); end
    tick();
    drive(1'b1, 32'hA2, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({bus.sram_req_o, bus.i_gnt_o} !== 2'b00) begin
      errors++; $display("FAIL b2b_full got %b%b want 00", bus.sram_req_o, bus.i_gnt_o);
    end
    tick();
    drive(1'b1, 32'hA2, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'hCAFE_0000);
    checks++;
    if ({bus.sram_req_o, bus.i_rvalid_o, bus.i_rdata_o} !== {1'b0, 1'b1, 32'hCAFE_0000}) begin
      errors++; $display("FAIL b2b_pop got %b%b %h want 01 cafe0000", bus.sram_req_o, bus.i_rvalid_o, bus.i_rdata_o);
    end
    tick();
    drive(1'b1, 32'hA2, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    checks++;
    if ({bus.sram_req_o, bus.i_gnt_o, bus.sram_addr_o} !== {2'b11, 32'hA2}) begin
      errors++; $display("FAIL b2b_g3 got %b%b %h want 11 a2", bus.sram_req_o, bus.i_gnt_o, bus.sram_addr_o);
    end
    tick();
    idle(1'b1, 32'hCAFE_0001);
    checks++;
    if ({bus.d_rvalid_o, bus.i_rvalid_o, bus.d_rdata_o} !== {2'b10, 32'hCAFE_0001}) begin
      errors++; $display("FAIL b2b_r2 got %b%b %h want 10 cafe0001", bus.d_rvalid_o, bus.i_rvalid_o, bus.d_rdata_o);
    end
    tick();
    idle(1'b1, 32'hCAFE_0002);
    checks++;
    if ({bus.i_rvalid_o, bus.d_rvalid_o, bus.i_rdata_o} !== {2'b10, 32'hCAFE_0002}) begin
      errors++; $display("FAIL b2b_r3 got %b%b %h want 10 cafe0002", bus.i_rvalid_o, bus.d_rvalid_o, bus.i_rdata_o);
    end
    tick();
  endtask

  task automatic test_unexpected();
    idle(1'b1, 32'hDEAD_BEEF);
    checks++;
    if ({bus.i_rvalid_o, bus.d_rvalid_o, bus.protocol_err_o} !== 3'b000) begin
      errors++; $display("FAIL unexp_drop got %b want 000", {bus.i_rvalid_o, bus.d_rvalid_o, bus.protocol_err_o});
    end
    tick();
    idle(1'b0, 32'h0);
    checks++;
    if (bus.protocol_err_o !== 1'b1) begin errors++; $display("FAIL unexp_pulse got %b want 1", bus.protocol_err_o); end
    tick();
    idle(1'b0, 32'h0);
    checks++;
    if (bus.protocol_err_o !== 1'b0) begin errors++; $display("FAIL unexp_end got %b want 0", bus.protocol_err_o); end
    tick();
  endtask

  task automatic test_reset_outstanding();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h300, 1'b1, 32'h400 + k, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0);
      checks++;
      if (bus.d_gnt_o !== 1'b1) begin errors++; $display("FAIL rsto_pre%0d got %b want 1", k, bus.d_gnt_o); end
      tick();
    end
    rst = 1'b1;
    idle(1'b0, 32'h0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idle(k < 2, 32'h7777_0000 + k);
      checks++;
      if ({bus.i_rvalid_o, bus.d_rvalid_o, bus.protocol_err_o} !== {2'b00, (k == 1) || (k == 2)}) begin
        errors++; $display("FAIL rsto_late%0d got %b want 00%b", k,
                           {bus.i_rvalid_o, bus.d_rvalid_o, bus.protocol_err_o}, (k == 1) || (k == 2));
      end
      tick();
    end
    starve_run("rsto_starve");
  endtask

  task automatic test_random();
    logic ip = 1'b0, dp = 1'b0, dwe = 1'b0, sgnt, srv;
    logic [31:0] ia = 32'h0, da = 32'h0, dwd = 32'h0;
    logic [3:0] dbe = 4'h0;
    for (int n = 0; n < 400; n++) begin
      if (!ip) begin ip = $urandom_range(0, 1); ia = $urandom; end
      if (!dp) begin dp = $urandom_range(0, 1); da = $urandom; dwe = $urandom_range(0, 1);
                     dbe = 4'($urandom); dwd = $urandom; end
      sgnt = ($urandom_range(0, 3) != 0);
      srv  = (idq.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
      rst  = ($urandom_range(0, 59) == 0);
      drive(ip, ia, dp, da, dwe, dbe, dwd, sgnt, srv, $urandom);
      checks++;
      if ({bus.sram_req_o, bus.i_gnt_o, bus.d_gnt_o, bus.i_rvalid_o, bus.d_rvalid_o, bus.protocol_err_o}
          !== {e_req, e_igt, e_dgt, e_irv, e_drv, e_perr}) begin
        errors++; $display("FAIL rnd_ctl cycle %0d got %b want %b", n,
          {bus.sram_req_o, bus.i_gnt_o, bus.d_gnt_o, bus.i_rvalid_o, bus.d_rvalid_o, bus.protocol_err_o},
          {e_req, e_igt, e_dgt, e_irv, e_drv, e_perr});
      end
      checks++;
      if ({bus.i_rdata_o, bus.d_rdata_o} !== {e_ird, e_drd}) begin
        errors++; $display("FAIL rnd_rdata cycle %0d got %h %h want %h %h", n,
                           bus.i_rdata_o, bus.d_rdata_o, e_ird, e_drd);
      end
      if ((ip || dp) && !rst) begin
        checks++;
        if ({bus.sram_addr_o, bus.sram_we_o, bus.sram_be_o, bus.sram_wdata_o} !== {e_addr, e_we, e_be, e_wd}) begin
          errors++; $display("FAIL rnd_fields cycle %0d got %h %b %h %h want %h %b %h %h", n,
            bus.sram_addr_o, bus.sram_we_o, bus.sram_be_o, bus.sram_wdata_o, e_addr, e_we, e_be, e_wd);
        end
      end
      if (e_igt || rst) ip = 1'b0;
      if (e_dgt || rst) dp = 1'b0;
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle(1'b0, 32'h0);
    @(posedge clk);
    #1;
    test_reset();
    test_instr_read();
    test_write();
    test_starvation();
    test_back_to_back();
    test_unexpected();
    test_reset_outstanding();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_obi_arbiter.md
SRAM_OBI_ARBITER -- requirements
Module: sram_obi_arbiter

Interface
- REQ-001: Parameter OSTD_DEPTH, default 2; maximum outstanding (granted, not yet responded) transactions; SHALL be a power of two, at least 2.
- REQ-002: Parameter STARVE_LIMIT, default 4; consecutive lost arbitration cycles after which the instruction port SHALL win; range 1..15.
- REQ-003: clk_i  in  1  sole clock; all state updates on rising edge.
- REQ-004: rst_i  in  1  reset; synchronous, active-high.
- REQ-005: i_req_i  in  1, i_gnt_o  out  1, i_addr_i  in  32  instruction OBI port, read-only.
- REQ-006: i_rvalid_o  out  1, i_rdata_o  out  32  instruction response.
- REQ-007: d_req_i  in  1, d_gnt_o  out  1, d_addr_i  in  32, d_we_i  in  1, d_be_i  in  4, d_wdata_i  in  32  data OBI request.
- REQ-008: d_rvalid_o  out  1, d_rdata_o  out  32  data response.
- REQ-009: sram_req_o  out  1, sram_gnt_i  in  1, sram_addr_o  out  32, sram_we_o  out  1, sram_be_o  out  4, sram_wdata_o  out  32  shared single-port SRAM request.
- REQ-010: sram_rvalid_i  in  1, sram_rdata_i  in  32  SRAM response; exactly one per accepted transaction (reads and writes), in order.
- REQ-011: protocol_err_o  out  1  one-cycle pulse on an unexpected SRAM response.

Function
- REQ-012: Arbitration and request muxing SHALL be combinational within one cycle; winner = data port, unless starve_cnt == STARVE_LIMIT and i_req_i is high, then instruction.
- REQ-013: If only one port requests, that port SHALL win.
- REQ-014: sram_req_o = (i_req_i | d_req_i) & !full; address, we, be and wdata SHALL come from the winner.
- REQ-015: When the instruction port wins: sram_we_o = 0, sram_be_o = 4'hF, sram_wdata_o = 0.
- REQ-016: Winner gnt = sram_gnt_i & sram_req_o; loser gnt = 0.
- REQ-017: Handshake (sram_req_o & sram_gnt_i) SHALL push the source ID (0 = instr, 1 = data) into an OSTD_DEPTH-entry ordered ID FIFO.
- REQ-018: full = (count == OSTD_DEPTH).
  - A pop in the same cycle SHALL NOT lift full; there is no combinational rvalid-to-gnt path.
- REQ-019: sram_rvalid_i with the FIFO non-empty SHALL pop the head ID and, in the same cycle (zero latency), assert the matching port's rvalid with rdata = sram_rdata_i; the other port's rvalid SHALL be 0.
- REQ-020: Routing and rdata SHALL be combinational; non-selected rdata SHALL be driven 0.
- REQ-021: Simultaneous push and pop SHALL leave count unchanged and preserve order.
- REQ-022: Pointer wrap-around SHALL be modulo OSTD_DEPTH.
- REQ-023: sram_rvalid_i with the FIFO empty SHALL be dropped (no port rvalid) and SHALL pulse protocol_err_o for one cycle, registered on the next edge.
- REQ-024: starve_cnt, 4 bits, SHALL update as follows:
  - increment (saturating at STARVE_LIMIT) when i_req_i is high and the data port completes a handshake;
  - clear when the instruction port completes a handshake or i_req_i is low;
  - otherwise hold.
- REQ-025: Requesters SHALL hold request fields stable until gnt; the block SHALL NOT register request fields.

Reset
- REQ-026: rst_i high at a rising edge SHALL empty the FIFO (pointers and count to 0), clear starve_cnt and clear protocol_err_o, regardless of outstanding transactions.
- REQ-027: While rst_i is high, all gnt, rvalid and sram_req_o outputs SHALL be 0.
- REQ-028: Responses arriving after reset for pre-reset transactions SHALL be treated as unexpected (REQ-023).

Verification
- REQ-029: Instr alone, sram_gnt_i = 1, addr 0x8000_0010, response 0x1234_5678 one cycle later -> i_gnt_o = 1 same cycle; i_rvalid_o = 1 with i_rdata_o = 0x1234_5678; d_rvalid_o = 0.
- REQ-030: Both ports request continuously, STARVE_LIMIT = 4 -> data granted 4 cycles, instr on the 5th, pattern repeats; starve_cnt = 0 after the instr grant.
- REQ-031: Data write be = 4'b0011, wdata 0xAABB_CCDD -> sram_we_o = 1, sram_be_o = 4'b0011; response routed to d_rvalid_o only.
- REQ-032: Responses withheld, 3 back-to-back requests, OSTD_DEPTH = 2 -> 2 grants, then sram_req_o = 0 until a response pops; 3rd granted the following cycle; order I, D, I preserved on return.
- REQ-033: sram_rvalid_i pulsed with nothing outstanding -> no port rvalid; protocol_err_o = 1 for exactly one cycle.
- REQ-034: rst_i asserted with 2 outstanding, then 2 late responses -> both dropped; protocol_err_o pulses twice; starve_cnt = 0.
